// File: rtl/siphash_msg_packer.sv
// Packs an 8-bit byte stream into little-endian 64-bit SipHash words,
// appends the length byte and sequences init/compress/finalize pulses.
// Ports:
//   clk, reset_n             : clock, async active-low reset
//   start, empty_msg         : begin message (empty_msg = zero-length)
//   in_data/in_valid/in_last : byte stream input
//   in_ready                 : byte accepted when in_valid & in_ready
//   core_ready               : downstream core ready status
//   core_init/compress/finalize, core_mi : core command pulses and word
//   busy, done               : status, one-cycle completion pulse
module siphash_msg_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        empty_msg,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  input  logic        core_ready,
  output logic        core_init,
  output logic        core_compress,
  output logic        core_finalize,
  output logic [63:0] core_mi,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_COLLECT,
    S_COMP,
    S_WAIT,
    S_FIN,
    S_FWAIT
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [2:0]  r_lane;
  logic [7:0]  r_len;
  logic        r_final;
  logic        r_tail;
  logic        r_empty;
  logic [63:0] r_mi;

  logic        w_acc;
  logic [7:0]  w_len_nxt;

  assign w_acc     = (r_state == S_COLLECT) && in_valid;
  assign w_len_nxt = r_len + 8'd1;
  assign core_mi   = r_mi;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_INIT;
      end
      S_INIT: begin
        w_next = r_empty ? S_COMP : S_COLLECT;
      end
      S_COLLECT: begin
        if (w_acc && ((r_lane == 3'd7) || in_last))
          w_next = S_COMP;
      end
      S_COMP: begin
        if (core_ready) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (core_ready) begin
          if (r_final)     w_next = S_FIN;
          else if (r_tail) w_next = S_COMP;
          else             w_next = S_COLLECT;
        end
      end
      S_FIN: begin
        if (core_ready) w_next = S_FWAIT;
      end
      S_FWAIT: begin
        if (core_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready      = (r_state == S_COLLECT);
    core_init     = (r_state == S_INIT);
    core_compress = (r_state == S_COMP) && core_ready;
    core_finalize = (r_state == S_FIN) && core_ready;
    busy          = (r_state != S_IDLE);
    done          = (r_state == S_FWAIT) && core_ready;
  end

  // Datapath: lane/length counters, flags and message word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lane  <= 3'd0;
      r_len   <= 8'd0;
      r_final <= 1'b0;
      r_tail  <= 1'b0;
      r_empty <= 1'b0;
      r_mi    <= 64'h0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_lane  <= 3'd0;
            r_len   <= 8'd0;
            r_final <= 1'b0;
            r_tail  <= 1'b0;
            r_empty <= empty_msg;
            r_mi    <= 64'h0;
          end
        end
        S_INIT: begin
          if (r_empty) begin
            r_mi    <= 64'h0;
            r_final <= 1'b1;
          end
        end
        S_COLLECT: begin
          if (w_acc) begin
            r_mi[{r_lane, 3'b000} +: 8] <= in_data;
            r_lane <= r_lane + 3'd1;
            r_len  <= w_len_nxt;
            if (in_last) begin
              // A short tail carries the length in its top lane;
              // a full last word needs a separate length-only word.
              if (r_lane != 3'd7) begin
                r_final     <= 1'b1;
                r_mi[63:56] <= w_len_nxt;
              end else begin
                r_tail <= 1'b1;
              end
            end
          end
        end
        S_WAIT: begin
          if (core_ready && !r_final) begin
            if (r_tail) begin
              r_mi    <= {r_len, 56'h0};
              r_final <= 1'b1;
              r_tail  <= 1'b0;
            end else begin
              r_mi   <= 64'h0;
              r_lane <= 3'd0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_siphash_msg_packer.sv
// Directed bench for siphash_msg_packer with a small core model
// whose ready drops for two cycles after each compress/finalize.
module tb_siphash_msg_packer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        empty_msg;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic        core_ready;
  logic        core_init;
  logic        core_compress;
  logic        core_finalize;
  logic [63:0] core_mi;
  logic        busy;
  logic        done;

  siphash_msg_packer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .empty_msg     (empty_msg),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .core_ready    (core_ready),
    .core_init     (core_init),
    .core_compress (core_compress),
    .core_finalize (core_finalize),
    .core_mi       (core_mi),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] r_cnt;
  logic       hold;
  assign core_ready = (r_cnt == 2'd0) && !hold;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        r_cnt <= 2'd0;
    else if (core_compress || core_finalize) r_cnt <= 2'd2;
    else if (r_cnt != 2'd0)              r_cnt <= r_cnt - 2'd1;
  end

  logic [63:0] words[$];
  int init_cnt = 0;
  int fin_cnt  = 0;
  int done_cnt = 0;
  int excl_bad = 0;

  always @(negedge clk) begin
    if (core_compress) words.push_back(core_mi);
    if (core_init)     init_cnt++;
    if (core_finalize) fin_cnt++;
    if (done)          done_cnt++;
    if ((32'(core_init) + 32'(core_compress) + 32'(core_finalize)) > 1)
      excl_bad++;
    if (!busy && (core_init || core_compress || core_finalize))
      excl_bad++;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic e);
    start     = 1'b1;
    empty_msg = e;
    @(negedge clk);
    start     = 1'b0;
    empty_msg = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int t;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("byte_timeout", 64'(t), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic wait_done(input int d0);
    int t;
    t = 0;
    while (done_cnt == d0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) chk("done_timeout", 64'(t), 64'd0);
    @(negedge clk);
  endtask

  task automatic run_msg(input int n, input logic [7:0] fixed,
                         input logic use_fixed);
    int d0;
    logic [7:0] b;
    d0 = done_cnt;
    do_start(n == 0);
    for (int i = 0; i < n; i++) begin
      b = use_fixed ? fixed : i[7:0];
      send_byte(b, i == n - 1);
    end
    wait_done(d0);
  endtask

  int base, i0, f0, d0, bad;
  logic [63:0] exp_w;

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    empty_msg = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    hold      = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_outs", {58'h0, in_ready, core_init, core_compress,
         core_finalize, busy, done}, 64'h0);
    chk("rst_mi", core_mi, 64'h0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", {63'h0, busy}, 64'h0);

    // Empty message
    base = words.size(); i0 = init_cnt; f0 = fin_cnt; d0 = done_cnt;
    run_msg(0, 8'h00, 1'b0);
    chk("empty_init", 64'(init_cnt - i0), 64'd1);
    chk("empty_ncomp", 64'(words.size() - base), 64'd1);
    chk("empty_w0", words[base], 64'h0);
    chk("empty_fin", 64'(fin_cnt - f0), 64'd1);
    chk("empty_done", 64'(done_cnt - d0), 64'd1);

    // 8 bytes: full word then a length-only word
    base = words.size(); f0 = fin_cnt;
    run_msg(8, 8'h00, 1'b0);
    chk("m8_ncomp", 64'(words.size() - base), 64'd2);
    chk("m8_w0", words[base], 64'h0706050403020100);
    chk("m8_w1", words[base+1], 64'h0800000000000000);
    chk("m8_fin", 64'(fin_cnt - f0), 64'd1);

    // 15 bytes: tail word carries length
    base = words.size();
    run_msg(15, 8'h00, 1'b0);
    chk("m15_ncomp", 64'(words.size() - base), 64'd2);
    chk("m15_w0", words[base], 64'h0706050403020100);
    chk("m15_w1", words[base+1], 64'h0f0e0d0c0b0a0908);

    // 256 bytes: length wraps to zero
    base = words.size();
    run_msg(256, 8'hAA, 1'b1);
    chk("m256_ncomp", 64'(words.size() - base), 64'd33);
    bad = 0;
    for (int k = 0; k < 32; k++)
      if (words[base+k] !== 64'hAAAAAAAAAAAAAAAA) bad++;
    chk("m256_aa", 64'(bad), 64'd0);
    chk("m256_last", words[base+32], 64'h0);

    // core_ready held low in COMP; stray start must be ignored
    base = words.size(); i0 = init_cnt; d0 = done_cnt;
    hold = 1'b1;
    do_start(1'b0);
    send_byte(8'h21, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h23, 1'b1);
    exp_w = 64'h0300000000232221;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (core_compress || in_ready || core_mi !== exp_w) bad++;
      start = (k == 2);
      @(negedge clk);
    end
    start = 1'b0;
    chk("hold_stall", 64'(bad), 64'd0);
    hold = 1'b0;
    #1;
    chk("hold_release", {63'h0, core_compress}, 64'd1);
    chk("hold_mi", core_mi, exp_w);
    wait_done(d0);
    chk("hold_ncomp", 64'(words.size() - base), 64'd1);
    chk("busy_start", 64'(init_cnt - i0), 64'd1);

    // Reset mid-message, then a fresh 1-byte message
    base = words.size(); f0 = fin_cnt; d0 = done_cnt;
    do_start(1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("mrst_outs", {58'h0, in_ready, core_init, core_compress,
         core_finalize, busy, done}, 64'h0);
    chk("mrst_mi", core_mi, 64'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mrst_quiet", 64'(words.size() - base + fin_cnt - f0 +
         done_cnt - d0), 64'd0);
    do_start(1'b0);
    send_byte(8'h11, 1'b1);
    chk("lat_comp", {63'h0, core_compress}, 64'd1);
    wait_done(d0);
    chk("mrst_ncomp", 64'(words.size() - base), 64'd1);
    chk("mrst_w0", words[base], 64'h0100000000000011);

    chk("excl", 64'(excl_bad), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/siphash_msg_packer.md
SIPHASH_MSG_PACKER -- requirements
Module: siphash_msg_packer

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 reset_n  in  1  asynchronous, active-low reset.
REQ-003 start  in  1  one-cycle request to begin a new message; honoured only in IDLE.
REQ-004 empty_msg  in  1  sampled with start; 1 means zero-length message.
REQ-005 in_data  in  8  message byte, arrives in message order.
REQ-006 in_valid  in  1  in_data valid.
REQ-007 in_last  in  1  qualifies in_data as final byte of message.
REQ-008 in_ready  out  1  byte accepted on cycles where in_valid and in_ready are both 1.
REQ-009 core_ready  in  1  ready status from the downstream SipHash core.
REQ-010 core_init  out  1  initialize pulse to core.
REQ-011 core_compress  out  1  compress pulse to core.
REQ-012 core_finalize  out  1  finalize pulse to core.
REQ-013 core_mi  out  64  message word to core; registered, stable while core_compress is 1.
REQ-014 busy  out  1  1 in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse when the core has finished finalization.

Function
REQ-016 Packing SHALL be little-endian: the k-th byte of a word goes to core_mi[8k+7:8k], k = 0..7.
REQ-017 An 8-bit length counter SHALL count accepted bytes and SHALL wrap modulo 256.
REQ-018 Final word SHALL be the 0..7 remaining bytes in the low lanes, zeros in the unused lanes, and the length counter in bits [63:56].
REQ-019 If a message length is a multiple of 8 (including 0), the last full word SHALL be compressed first; then a final word {len, 56'h0} SHALL be compressed.
REQ-020 FSM states and transitions:
- IDLE: start=1 -> INIT. Clears the byte lane, length counter and final flags. Latches empty_msg.
- INIT: core_init=1 for exactly one cycle. If empty_msg was latched: load core_mi=64'h0, set final flag, go to COMP. Otherwise go to COLLECT.
- COLLECT: in_ready=1. Each accepted byte is written to its lane; the lane and length counter increment. If the 8th lane is filled or in_last=1, go to COMP. If in_last=1 and the lane was not 7, set the final flag and insert the length byte. If in_last=1 and the lane was 7, set the tail-pending flag.
- COMP: core_compress = core_ready. Leave for WAIT only on a cycle where core_compress=1; otherwise hold.
- WAIT: hold until core_ready=1, then branch in this priority order:
  - final flag set -> FIN.
  - tail pending set -> load {len, 56'h0}, set final flag, clear tail pending, go to COMP.
  - otherwise -> clear core_mi and lane, go to COLLECT.
- FIN: core_finalize = core_ready. Go to FWAIT on a cycle where core_finalize=1.
- FWAIT: hold until core_ready=1, then done=1 for that cycle and go to IDLE.
REQ-021 in_ready SHALL be 0 outside COLLECT; bytes presented outside COLLECT SHALL be neither accepted nor counted.
REQ-022 core_init, core_compress and core_finalize SHALL be mutually exclusive and never asserted in IDLE.
REQ-023 start SHALL be ignored when busy=1.
REQ-024 core_compress SHALL assert in the cycle directly after the 8th-byte or last-byte acceptance if core_ready=1 in that cycle.
REQ-025 Core ready drops in the cycle after a compress or finalize; WAIT and FWAIT SHALL therefore not exit before the core reasserts core_ready.
REQ-026 in_last SHALL have effect only on an accepted byte.

Reset
REQ-027 While reset_n=0, all outputs SHALL be 0, core_mi SHALL be 64'h0, and the state SHALL be IDLE, with the length counter, lane and flags cleared.
REQ-028 Reset asserted mid-message SHALL abandon the message with no further pulses to the core; the next start SHALL begin a fresh message.

Verification
REQ-029 start with empty_msg=1 -> core_init, then core_compress with core_mi=64'h0000000000000000, then core_finalize, then done.
REQ-030 8 bytes 00..07 (last on 07) -> compress 64'h0706050403020100, then compress 64'h0800000000000000, then finalize, then done.
REQ-031 15 bytes 00..0e -> compress 64'h0706050403020100, then compress 64'h0f0e0d0c0b0a0908, then finalize.
REQ-032 256 bytes of 8'hAA -> 32 compresses of 64'hAAAAAAAAAAAAAAAA, then a final word 64'h0000000000000000 (length wraps to 0).
REQ-033 core_ready held 0 for 5 cycles in COMP -> core_compress stays 0, in_ready stays 0, core_mi is unchanged; compress occurs on the first cycle with core_ready=1.
REQ-034 reset_n pulsed low after 3 bytes -> all outputs 0 and busy=0; a new 1-byte message 8'h11 then yields compress 64'h0100000000000011.
